// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - store port and data-memory write port bundle for store_unit
interface store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic [1:0]        st_size;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_ready;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              misalign;

  modport master (
    output st_valid, st_size, st_addr, st_data, mem_ack,
    input  st_ready, stall, mem_req, mem_addr, mem_wdata, mem_be, misalign
  );

  modport slave (
    input  st_valid, st_size, st_addr, st_data, mem_ack,
    output st_ready, stall, mem_req, mem_addr, mem_wdata, mem_be, misalign
  );
endinterface

// File: rtl/store_unit.sv
// rtl/store_unit.sv - packs core stores into word-aligned byte-enabled memory writes
// Optional misaligned-store trap enabled by defining STORE_MISALIGN_TRAP_EN.
module store_unit #(
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        rst,
  store_unit_if.slave bus
);
  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic              ready;
  logic              accept;
  logic              drop;
  logic              mis;
  logic [ADDR_W-1:0] pk_addr;
  logic [31:0]       pk_wdata;
  logic [3:0]        pk_be;

  assign ready  = (state == IDLE) | bus.mem_ack;
  assign accept = bus.st_valid & ready;

  assign bus.st_ready  = ready;
  assign bus.stall     = bus.st_valid & ~ready;
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

`ifdef STORE_MISALIGN_TRAP_EN
  logic mis_q;

  always_comb begin
    mis = 1'b0;
    case (bus.st_size)
      2'b01:   mis = bus.st_addr[0];
      2'b10:   mis = (bus.st_addr[1:0] != 2'b00);
      default: mis = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= accept & mis;
  end

  assign bus.misalign = mis_q;
`else
  assign mis          = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  // Reserved size and trapped misaligned stores are consumed without a write.
  assign drop = (bus.st_size == 2'b11) | mis;

  always_comb begin
    pk_addr  = {bus.st_addr[ADDR_W-1:2], 2'b00};
    pk_wdata = bus.st_data;
    pk_be    = 4'b1111;
    case (bus.st_size)
      2'b00: begin
        pk_wdata = {4{bus.st_data[7:0]}};
        pk_be    = 4'b0001 << bus.st_addr[1:0];
      end
      2'b01: begin
        pk_wdata = {2{bus.st_data[15:0]}};
        pk_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        pk_wdata = bus.st_data;
        pk_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !drop) begin
            state   <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pk_addr;
            wdata_q <= pk_wdata;
            be_q    <= pk_be;
          end
        end
        REQ: begin
          // Outputs hold until the memory acks; a same-cycle store chains directly.
          if (bus.mem_ack) begin
            if (accept && !drop) begin
              state   <= REQ;
              req_q   <= 1'b1;
              addr_q  <= pk_addr;
              wdata_q <= pk_wdata;
              be_q    <= pk_be;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
              be_q  <= 4'b0000;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          be_q  <= 4'b0000;
        end
      endcase
    end
  end
endmodule
